// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester shared-ALU sequencer.
package alu_share_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLG_W  = 3;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;

    localparam int unsigned FLG_OVF  = 2;
    localparam int unsigned FLG_NEG  = 1;
    localparam int unsigned FLG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arb.sv
// Two-way arbiter with one-hot grant.
// ALU_SHARE_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module alu_share_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ALU_SHARE_RR_EN
    // last_q = 1 means requester 1 was granted last; reset so requester 0 wins first
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, accept};

    always_comb begin
        grant = 2'b00;
        if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer sharing one external ALU between two requesters, tagged response channel.
// Arbitration policy selected by ALU_SHARE_RR_EN (round-robin) vs. fixed priority.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_ain,
    output logic [WIDTH-1:0] alu_bin,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [2:0]       alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    logic [1:0]       grant;
    logic             accept;
    logic [WIDTH-1:0] a_q, b_q;
    logic [OPW-1:0]   op_q;
    logic             id_q;
    logic             legal_c, logic_op_c;
    logic [2:0]       flags_c;

    alu_share_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is a same-cycle grant, only offered in IDLE and never while reset is held
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    accept     = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= grant[1] ? req1_a  : req0_a;
            b_q  <= grant[1] ? req1_b  : req0_b;
            op_q <= grant[1] ? req1_op : req0_op;
            id_q <= grant[1];
        end
    end

    assign alu_ain = a_q;
    assign alu_bin = b_q;
    assign alu_op  = op_q;

    assign logic_op_c = (op_q == OPW'(OP_AND)) || (op_q == OPW'(OP_OR));
    assign legal_c    = logic_op_c || (op_q == OPW'(OP_ADD)) || (op_q == OPW'(OP_SUB));

    // Logic ops cannot overflow; illegal ops report no flags at all
    always_comb begin
        flags_c = alu_z;
        if (!legal_c) begin
            flags_c = 3'b000;
        end else if (logic_op_c) begin
            flags_c[FLG_OVF] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 3'b000;
            rsp_err    <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= legal_c ? alu_out : '0;
            rsp_flags  <= flags_c;
            rsp_err    <= !legal_c;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural ALU model.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_ain, alu_bin, alu_out;
    logic [3:0]  alu_op;
    logic [2:0]  alu_z;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        force_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_ain    (alu_ain),
        .alu_bin    (alu_bin),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_z      (alu_z),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
    );

    // Behavioural shared ALU; illegal ops return junk so the controller must mask it
    always_comb begin
        logic [31:0] r;
        logic        ov;
        r  = 32'hDEAD_BEEF;
        ov = 1'b1;
        case (alu_op)
            4'b0000: begin r = alu_ain & alu_bin; ov = force_ovf; end
            4'b0001: begin r = alu_ain | alu_bin; ov = force_ovf; end
            4'b0010: begin
                r  = alu_ain + alu_bin;
                ov = (alu_ain[31] == alu_bin[31]) && (r[31] != alu_ain[31]);
            end
            4'b0110: begin
                r  = alu_ain - alu_bin;
                ov = (alu_ain[31] != alu_bin[31]) && (r[31] != alu_ain[31]);
            end
            default: begin r = 32'hDEAD_BEEF; ov = 1'b1; end
        endcase
        alu_out = r;
        alu_z   = {ov, r[31], r == 32'd0};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One op from a single requester: ready at t, nothing at t+1, response at t+2
    task automatic run_op(input bit r, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] er,
                          input logic [2:0] ef, input bit ee);
        @(negedge clk);
        if (r) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        chk("ready_t", {req1_ready, req0_ready}, r ? 2'b10 : 2'b01);
        chk("valid_t", rsp_valid, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("valid_t1", rsp_valid, 1'b0);
        chk("alu_ain", alu_ain, a);
        chk("alu_bin", alu_bin, b);
        chk("alu_op", alu_op, op);
        @(negedge clk);
        chk("valid_t2", rsp_valid, 1'b1);
        chk("result", rsp_result, er);
        chk("flags", rsp_flags, ef);
        chk("id", rsp_id, r);
        chk("err", rsp_err, ee);
    endtask

    initial begin
        logic [3:0] exp_ids;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b1;
        force_ovf = 1'b0;
`ifdef ALU_SHARE_RR_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_misc", {rsp_id, rsp_err, rsp_flags}, 5'd0);
        chk("rst_alu", {alu_ain, alu_bin}, 64'd0);
        chk("rst_alu_op", alu_op, 4'b0000);
        rst = 1'b0;

        run_op(1'b0, 32'd5, 32'd7, OP_ADD, 32'd12, 3'b000, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'd1, OP_SUB, 32'h7FFF_FFFF, 3'b100, 1'b0);
        force_ovf = 1'b1;
        run_op(1'b0, 32'hF0F0_0000, 32'h0F0F_0000, OP_AND, 32'd0, 3'b001, 1'b0);
        force_ovf = 1'b0;
        run_op(1'b1, 32'd3, 32'd4, 4'b1111, 32'd0, 3'b000, 1'b1);

        // Both requesters valid continuously for four ops
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = OP_ADD;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid && n < 10);
            if (!rsp_valid) chk("arb_timeout", 1'b0, 1'b1);
            else begin
                chk("arb_id", rsp_id, exp_ids[k]);
                chk("arb_result", rsp_result, exp_ids[k] ? 32'd4 : 32'd2);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Stalled response, then reset while in RESP
        rsp_ready = 1'b0;
        run_op(1'b0, 32'h0000_1234, 32'h0000_00F0, OP_OR, 32'h0000_12F4, 3'b000, 1'b0);
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = OP_ADD;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_result", rsp_result, 32'h0000_12F4);
            chk("stall_id_err", {rsp_id, rsp_err, rsp_flags}, 5'd0);
            chk("stall_ready", {req1_ready, req0_ready}, 2'b00);
        end
        rst = 1'b1;
        #1;
        chk("rstmid_valid", rsp_valid, 1'b0);
        chk("rstmid_result", rsp_result, 32'd0);
        chk("rstmid_ready", {req1_ready, req0_ready}, 2'b00);
        chk("rstmid_alu", {alu_ain, alu_op}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
        #1;
        chk("post_rst_ready", {req1_ready, req0_ready}, 2'b01);
        chk("post_rst_valid", rsp_valid, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("post_rst_t1", rsp_valid, 1'b0);
        @(negedge clk);
        chk("post_rst_t2", rsp_valid, 1'b1);
        chk("post_rst_id", rsp_id, 1'b0);
        chk("post_rst_result", rsp_result, 32'd2);
        @(negedge clk);
        chk("post_rst_done", rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer that shares one combinational ALU (AND/OR/ADD/SUB with overflow/negative/zero flags) between two requesters. Each requester presents operands and an opcode over a valid/ready handshake. The controller arbitrates, drives the ALU from registered operands, captures the result and flags, and returns them on a single tagged response channel. It sits between the issue logic and the shared ALU datapath.

## Interface
- WIDTH, 32, operand/result width
- OPW, 4, opcode width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  OPW  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  as above, requester 1
- alu_ain, alu_bin  out  WIDTH  operands to shared ALU
- alu_op  out  OPW  opcode to shared ALU
- alu_out  in  WIDTH  ALU result
- alu_z  in  3  ALU flags: [2] overflow, [1] negative, [0] zero
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued this response
- rsp_result  out  WIDTH  captured result
- rsp_flags  out  3  captured flags, same bit order as alu_z
- rsp_err  out  1  opcode was illegal

## Operation
- Legal opcodes: 4'b0000 AND (bitwise), 4'b0001 OR (bitwise), 4'b0010 ADD, 4'b0110 SUB. All others are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, the arbiter picks a winner. In the same cycle the controller asserts the winner's reqN_ready combinationally, and latches a, b, op and id into internal registers. Next state is EXEC. With no valid, it stays in IDLE.
- EXEC: alu_ain/alu_bin/alu_op are driven from the internal registers, and alu_out and alu_z are sampled at the end of the cycle. Next state is RESP.
- Flag capture rules:
  - ADD/SUB: rsp_flags = alu_z.
  - AND/OR: rsp_flags[2] is forced to 0. Bits [1:0] are taken from alu_z.
  - Illegal op: rsp_result = 0, rsp_flags = 3'b000, rsp_err = 1. The op still passes through EXEC so timing is uniform.
- RESP: rsp_valid = 1. Response fields hold stable until rsp_ready is high. On rsp_valid && rsp_ready the next state is IDLE. Requests are never accepted in RESP or EXEC.
- reqN_ready is 0 in every state except IDLE.
- alu_* outputs hold the last registered value outside EXEC (no glitching to X).

## Timing
- Accept in cycle t. rsp_valid rises in cycle t+2.
- The earliest next accept is in the cycle after the response handshake. Peak throughput is one op per 3 cycles.
- Reset values:
  - state = IDLE.
  - req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err = 0.
  - rsp_result, alu_ain, alu_bin = 0.
  - alu_op = 4'b0000.
  - rsp_flags = 3'b000.
  - Round-robin pointer set so requester 0 wins first.
- If rst asserts in EXEC or RESP, the in-flight op is dropped with no response, and all outputs return to reset values immediately.
- A requester must hold valid and payload stable until ready. If valid drops while not ready, the request is withdrawn without side effect.

## Configuration
- ALU_SHARE_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on each accept.
  - When both are valid, the requester not granted last time wins.
- ALU_SHARE_RR_EN undefined: fixed priority. Requester 0 always wins when both are valid, and the pointer logic is absent.

## Structure
- The shared package holds:
  - opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB
  - flag bit indices FLG_OVF=2, FLG_NEG=1, FLG_ZERO=0
  - FSM state enum (IDLE, EXEC, RESP)
- One sub-module: alu_share_arb, a 2-way arbiter. Its inputs are the two valids and an accept strobe. Its output is a one-hot grant. It contains the pointer when ALU_SHARE_RR_EN is defined.
- The ALU itself is instantiated outside this block.

## Test plan
- Single ADD from req0, a=5, b=7, rsp_ready=1 → req0_ready in cycle t, rsp_valid in t+2, result 12, flags 000, id 0, err 0.
- SUB from req1, a=32'h8000_0000, b=1 → result 32'h7FFF_FFFF, flags 100 (overflow), id 1.
- AND from req0, a=32'hF0F0_0000, b=32'h0F0F_0000 → result 0, flags 001. Drive alu_z[2]=1 from the model and check rsp_flags[2]=0.
- Both valid continuously, 4 ops:
  - RR_EN defined: ids 0,1,0,1.
  - RR_EN undefined: ids 0,0,0,0.
- Illegal op 4'b1111 from req1 → rsp_err=1, result 0, flags 000, still returned at t+2.
- rsp_ready held low for 5 cycles:
  - rsp fields stay stable.
  - both reqN_ready stay 0.
  - Then pulse rst in RESP: rsp_valid drops immediately, no response after reset, and the next accept goes to req0.
